obj_det_seq_ctrl: RTL

OBJ_DET_SEQ_CTRL -- requirements
Module: obj_det_seq_ctrl

---
 rtl/obj_det_pkg.sv | 23 ++
 rtl/obj_det_level_latch.sv | 21 ++
 rtl/obj_det_seq_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/obj_det_pkg.sv
// Shared types and sizing helpers for the object-detection sequence controller.
package obj_det_pkg;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_WAIT_START,
        ST_SYNC,
        ST_CAPTURE_REF,
        ST_START_FRAME,
        ST_PROC_FRAME,
        ST_SKIP_FRAME
    } state_t;

    function automatic int unsigned frame_size(input int unsigned h_res, input int unsigned v_res);
        return h_res * v_res;
    endfunction

    // Smallest pixel address width that can cover a whole frame.
    function automatic int unsigned min_addr_w(input int unsigned h_res, input int unsigned v_res);
        return $clog2(h_res * v_res);
    endfunction

endpackage

// File: rtl/obj_det_level_latch.sv
// Turns a one-cycle set pulse into a held level; clear wins over set.
module obj_det_level_latch (
    input  logic clk,
    input  logic resetn,
    input  logic set,
    input  logic clr,
    output logic q
);

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q <= 1'b0;
        end else if (clr) begin
            q <= 1'b0;
        end else if (set) begin
            q <= 1'b1;
        end
    end

endmodule

// File: rtl/obj_det_seq_ctrl.sv
// Frame sequencer steering camera pixels into reference/difference BRAMs.
// Optional periodic reference recapture is enabled by defining OBJ_DET_REF_REFRESH_EN.
module obj_det_seq_ctrl
    import obj_det_pkg::*;
#(
    parameter int unsigned H_RES  = 320,
    parameter int unsigned V_RES  = 240,
    parameter int          ADDR_W = 17,
    parameter int          SKIP_W = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i2c_config_done,
    input  logic              start_capture,
    input  logic              stop_capture,
    input  logic [ADDR_W-1:0] capture_addr,
    input  logic              capture_wren,
    input  logic [SKIP_W-1:0] frame_skip,
    input  logic [15:0]       refresh_period,
    output logic              resetn_datapath,
    output logic [ADDR_W-1:0] ref_addr,
    output logic [ADDR_W-1:0] diff_addr,
    output logic              ref_wren,
    output logic              diff_wren,
    output logic              ref_bram_enable,
    output logic              diff_bram_enable,
    output logic              init_done,
    output logic              frame_start,
    output logic              frame_done,
    output logic              ref_refresh,
    output logic [15:0]       proc_frame_count,
    output logic              busy
);

    localparam int unsigned       FRAME_SIZE = frame_size(H_RES, V_RES);
    localparam logic [ADDR_W:0]   FRAME_END  = (ADDR_W + 1)'(FRAME_SIZE);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FRAME_SIZE - 1);

    state_t state, state_next, sync_dest, dp_state;

    logic              pix_valid, last_pix, boundary, refresh_due;
    logic              force_idle, clear_cnt, init_set, init_clr;
    logic              frame_complete, skip_complete;
    logic              frame_done_q;
    logic [15:0]       proc_cnt;
    logic [SKIP_W-1:0] skip_cnt;

    // Addresses beyond the frame are stray and must never write or advance the FSM.
    assign pix_valid = capture_wren && ({1'b0, capture_addr} < FRAME_END);
    assign last_pix  = pix_valid && (capture_addr == LAST_ADDR);
    assign boundary  = capture_wren && (capture_addr == '0);

    assign busy             = (state != ST_RESET) && (state != ST_WAIT_START);
    assign resetn_datapath  = busy;
    assign frame_start      = (state == ST_START_FRAME);
    assign frame_done       = frame_done_q;
    assign proc_frame_count = proc_cnt;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next     = state;
        sync_dest      = ST_START_FRAME;
        force_idle     = 1'b0;
        clear_cnt      = 1'b0;
        init_set       = 1'b0;
        init_clr       = 1'b0;
        frame_complete = 1'b0;
        skip_complete  = 1'b0;

        if (!init_done || refresh_due) begin
            sync_dest = ST_CAPTURE_REF;
        end else if (skip_cnt != '0) begin
            sync_dest = ST_SKIP_FRAME;
        end

        // The frame-first pixel seen in SYNC is handled by the state it leads into.
        dp_state = (state == ST_SYNC && boundary) ? sync_dest : state;

        if (state != ST_RESET && !i2c_config_done) begin
            state_next = ST_RESET;
            force_idle = 1'b1;
            clear_cnt  = 1'b1;
            init_clr   = 1'b1;
        end else if (busy && stop_capture) begin
            state_next = ST_WAIT_START;
            force_idle = 1'b1;
            clear_cnt  = 1'b1;
            init_clr   = 1'b1;
        end else begin
            case (state)
                ST_RESET: begin
                    if (i2c_config_done) state_next = ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    if (start_capture && !stop_capture) state_next = ST_SYNC;
                end
                ST_SYNC: begin
                    if (boundary) state_next = sync_dest;
                end
                ST_CAPTURE_REF: begin
                    if (last_pix) begin
                        init_set   = 1'b1;
                        state_next = ST_SYNC;
                    end
                end
                ST_START_FRAME, ST_PROC_FRAME: begin
                    if (last_pix) begin
                        frame_complete = 1'b1;
                        state_next     = ST_SYNC;
                    end else begin
                        state_next = ST_PROC_FRAME;
                    end
                end
                ST_SKIP_FRAME: begin
                    if (last_pix) begin
                        skip_complete = 1'b1;
                        state_next    = ST_SYNC;
                    end
                end
                default: state_next = ST_RESET;
            endcase
        end
    end

    always_comb begin
        ref_addr         = '0;
        diff_addr        = '0;
        ref_wren         = 1'b0;
        diff_wren        = 1'b0;
        ref_bram_enable  = 1'b1;
        diff_bram_enable = 1'b1;

        case (dp_state)
            ST_WAIT_START: begin
                ref_bram_enable  = 1'b0;
                diff_bram_enable = 1'b0;
            end
            ST_CAPTURE_REF: begin
                ref_addr         = capture_addr;
                diff_addr        = capture_addr;
                ref_wren         = pix_valid && !force_idle;
                diff_wren        = pix_valid && !force_idle;
                ref_bram_enable  = capture_wren;
                diff_bram_enable = capture_wren;
            end
            ST_START_FRAME, ST_PROC_FRAME: begin
                ref_addr         = capture_addr;
                diff_addr        = capture_addr;
                diff_wren        = pix_valid && !force_idle;
                diff_bram_enable = capture_wren;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_RESET;
            frame_done_q <= 1'b0;
            proc_cnt     <= '0;
            skip_cnt     <= '0;
        end else begin
            state        <= state_next;
            frame_done_q <= frame_complete;
            if (clear_cnt) begin
                proc_cnt <= '0;
                skip_cnt <= '0;
            end else if (frame_complete) begin
                proc_cnt <= proc_cnt + 16'd1;
                skip_cnt <= frame_skip;
            end else if (skip_complete) begin
                skip_cnt <= skip_cnt - SKIP_W'(1);
            end
        end
    end

`ifdef OBJ_DET_REF_REFRESH_EN
    logic [15:0] refresh_cnt;
    logic        refresh_start, ref_refresh_q;

    // Counts processed frames since the reference was last written.
    assign refresh_due   = (refresh_period != 16'd0) && (refresh_cnt == refresh_period);
    assign refresh_start = (state == ST_SYNC) && boundary && init_done && refresh_due && !force_idle;
    assign ref_refresh   = ref_refresh_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            refresh_cnt   <= '0;
            ref_refresh_q <= 1'b0;
        end else begin
            ref_refresh_q <= refresh_start;
            if (clear_cnt || init_set) begin
                refresh_cnt <= '0;
            end else if (frame_complete) begin
                refresh_cnt <= refresh_cnt + 16'd1;
            end
        end
    end
`else
    logic unused_refresh_period;

    assign unused_refresh_period = ^refresh_period;
    assign refresh_due           = 1'b0;
    assign ref_refresh           = 1'b0;
`endif

    obj_det_level_latch u_init_latch (
        .clk    (clk),
        .resetn (resetn),
        .set    (init_set),
        .clr    (init_clr),
        .q      (init_done)
    );

endmodule
